// File: rtl/fsa_colscan_pkg.sv
// Shared definitions for the column-record scanner: FSM encoding and the
// default read latency of the column-record RAM banks.
package fsa_colscan_pkg;

  localparam int unsigned C_RD_LAT_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fsa_colscan_if.sv
// Column-record read bus plus result handshake of the column scanner.
// master = scanner side, slave = RAM banks / result consumer side.
interface fsa_colscan_if #(
  parameter int unsigned C_IMG_HW = 12,
  parameter int unsigned C_IMG_WW = 12,
  parameter int unsigned BR_NUM   = 4,
  parameter int unsigned BR_AW    = 12
);

  logic                rd_en;
  logic [BR_NUM-1:0]   rd_sel;
  logic [BR_AW-1:0]    rd_addr;
  logic                rd_val_outer;
  logic                rd_val_inner;
  logic [C_IMG_HW-1:0] rd_top_outer;
  logic [C_IMG_HW-1:0] rd_bot_outer;
  logic [C_IMG_HW-1:0] rd_top_inner;
  logic [C_IMG_HW-1:0] rd_bot_inner;

  logic                m_valid;
  logic                m_ready;
  logic                res_found_outer;
  logic                res_found_inner;
  logic [C_IMG_WW-1:0] res_left;
  logic [C_IMG_WW-1:0] res_right;
  logic [C_IMG_HW-1:0] res_top_outer;
  logic [C_IMG_HW-1:0] res_bot_outer;
  logic [C_IMG_HW-1:0] res_top_inner;
  logic [C_IMG_HW-1:0] res_bot_inner;

  modport master (
    output rd_en, rd_sel, rd_addr,
    input  rd_val_outer, rd_val_inner,
    input  rd_top_outer, rd_bot_outer, rd_top_inner, rd_bot_inner,
    output m_valid,
    input  m_ready,
    output res_found_outer, res_found_inner, res_left, res_right,
    output res_top_outer, res_bot_outer, res_top_inner, res_bot_inner
  );

  modport slave (
    input  rd_en, rd_sel, rd_addr,
    output rd_val_outer, rd_val_inner,
    output rd_top_outer, rd_bot_outer, rd_top_inner, rd_bot_inner,
    input  m_valid,
    output m_ready,
    input  res_found_outer, res_found_inner, res_left, res_right,
    input  res_top_outer, res_bot_outer, res_top_inner, res_bot_inner
  );

endinterface

// File: rtl/fsa_minmax_acc.sv
// Bounding accumulator: remembers first/last valid column and the
// min top / max bottom row over all valid columns since the last clear.
module fsa_minmax_acc #(
  parameter int unsigned C_IMG_HW = 12,
  parameter int unsigned C_IMG_WW = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic [C_IMG_WW-1:0] col,
  input  logic [C_IMG_HW-1:0] in_top,
  input  logic [C_IMG_HW-1:0] in_bot,
  output logic                found,
  output logic [C_IMG_WW-1:0] left,
  output logic [C_IMG_WW-1:0] right,
  output logic [C_IMG_HW-1:0] top_min,
  output logic [C_IMG_HW-1:0] bot_max
);

  // First valid column seeds all fields; later ones extend the bounds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      found   <= 1'b0;
      left    <= '0;
      right   <= '0;
      top_min <= '0;
      bot_max <= '0;
    end else if (clr) begin
      found   <= 1'b0;
      left    <= '0;
      right   <= '0;
      top_min <= '0;
      bot_max <= '0;
    end else if (en) begin
      right <= col;
      if (!found) begin
        found   <= 1'b1;
        left    <= col;
        top_min <= in_top;
        bot_max <= in_bot;
      end else begin
        if (in_top < top_min) top_min <= in_top;
        if (in_bot > bot_max) bot_max <= in_bot;
      end
    end
  end

endmodule

// File: rtl/fsa_colscan.sv
// Column scanner: walks a column window of one record bank, accumulates the
// outer and inner bounding boxes, and presents them on a valid/ready port.
module fsa_colscan
  import fsa_colscan_pkg::*;
#(
  parameter int unsigned C_IMG_HW = 12,
  parameter int unsigned C_IMG_WW = 12,
  parameter int unsigned BR_NUM   = 4,
  parameter int unsigned BR_AW    = 12,
  parameter int unsigned C_RD_LAT = C_RD_LAT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sof,
  input  logic [BR_NUM-1:0]   rd_bmp,
  input  logic [C_IMG_WW-1:0] width,
  input  logic [C_IMG_WW-1:0] win_left,
  input  logic [C_IMG_WW-1:0] win_width,
  output logic                busy,
  output logic [7:0]          drop_cnt,
  fsa_colscan_if.master       bus
);

  localparam int unsigned CW = $clog2(C_RD_LAT + 1);

  state_t                          state, state_nxt;
  logic [BR_NUM-1:0]               bmp_q;
  logic [C_IMG_WW-1:0]             x_q;
  logic [C_IMG_WW:0]               xe_q;
  logic [CW-1:0]                   drain_cnt;
  logic [C_IMG_WW:0]               xe_win, xe_img, xe_sel;
  logic                            skip, start;
  logic [C_RD_LAT-1:0]             sr_vld;
  logic [C_RD_LAT-1:0][BR_AW-1:0]  sr_addr;
  logic                            consume;
  logic [C_IMG_WW-1:0]             consume_col;
  logic [C_IMG_WW-1:0]             inner_left_unused, inner_right_unused;

  // Window end clipped to the image, one extra bit so the sum cannot wrap.
  always_comb begin
    xe_win = {1'b0, win_left} + {1'b0, win_width} - (C_IMG_WW + 1)'(1);
    xe_img = {1'b0, width} - (C_IMG_WW + 1)'(1);
    xe_sel = (xe_win < xe_img) ? xe_win : xe_img;
    skip   = (win_width == '0) || (win_left >= width);
    start  = (state == ST_IDLE) && sof;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and bus outputs decoded from the current state.
  always_comb begin
    state_nxt   = state;
    bus.rd_en   = 1'b0;
    bus.rd_sel  = '0;
    bus.rd_addr = '0;
    bus.m_valid = 1'b0;
    busy        = (state != ST_IDLE);
    unique case (state)
      ST_IDLE:  if (sof) state_nxt = skip ? ST_DONE : ST_SCAN;
      ST_SCAN: begin
        bus.rd_en   = 1'b1;
        bus.rd_sel  = bmp_q;
        bus.rd_addr = BR_AW'(x_q);
        if ({1'b0, x_q} == xe_q) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        bus.rd_sel = bmp_q;
        if (drain_cnt == CW'(C_RD_LAT - 1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        bus.m_valid = 1'b1;
        if (bus.m_ready) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Scan context captured on an accepted sof; column pointer and drain timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bmp_q     <= '0;
      x_q       <= '0;
      xe_q      <= '0;
      drain_cnt <= '0;
    end else if (start) begin
      bmp_q     <= rd_bmp;
      x_q       <= win_left;
      xe_q      <= xe_sel;
      drain_cnt <= '0;
    end else if (state == ST_SCAN) begin
      x_q <= x_q + C_IMG_WW'(1);
    end else if (state == ST_DRAIN) begin
      drain_cnt <= drain_cnt + CW'(1);
    end
  end

  // sof pulses seen while busy are dropped and counted, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                drop_cnt <= '0;
    else if (sof && busy && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

  // Delay line aligning each issued read with its returned record.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_vld  <= '0;
      sr_addr <= '0;
    end else begin
      sr_vld[0]  <= bus.rd_en;
      sr_addr[0] <= bus.rd_addr;
      for (int unsigned i = 1; i < C_RD_LAT; i++) begin
        sr_vld[i]  <= sr_vld[i-1];
        sr_addr[i] <= sr_addr[i-1];
      end
    end
  end

  assign consume     = sr_vld[C_RD_LAT-1];
  assign consume_col = C_IMG_WW'(sr_addr[C_RD_LAT-1]);

  fsa_minmax_acc #(.C_IMG_HW(C_IMG_HW), .C_IMG_WW(C_IMG_WW)) u_acc_outer (
    .clk     (clk),
    .reset   (reset),
    .clr     (start),
    .en      (consume && bus.rd_val_outer),
    .col     (consume_col),
    .in_top  (bus.rd_top_outer),
    .in_bot  (bus.rd_bot_outer),
    .found   (bus.res_found_outer),
    .left    (bus.res_left),
    .right   (bus.res_right),
    .top_min (bus.res_top_outer),
    .bot_max (bus.res_bot_outer)
  );

  fsa_minmax_acc #(.C_IMG_HW(C_IMG_HW), .C_IMG_WW(C_IMG_WW)) u_acc_inner (
    .clk     (clk),
    .reset   (reset),
    .clr     (start),
    .en      (consume && bus.rd_val_inner),
    .col     (consume_col),
    .in_top  (bus.rd_top_inner),
    .in_bot  (bus.rd_bot_inner),
    .found   (bus.res_found_inner),
    .left    (inner_left_unused),
    .right   (inner_right_unused),
    .top_min (bus.res_top_inner),
    .bot_max (bus.res_bot_inner)
  );

endmodule

// File: tb/tb_fsa_colscan.sv
// Directed bench for fsa_colscan: a 3-cycle-latency column-record memory
// model with a 64-entry table, and hand-computed expected results.
module tb_fsa_colscan;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sof = 1'b0;
  logic [3:0]  rd_bmp = '0;
  logic [11:0] width = '0;
  logic [11:0] win_left = '0;
  logic [11:0] win_width = '0;
  logic        busy;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fsa_colscan_if #(.C_IMG_HW(12), .C_IMG_WW(12), .BR_NUM(4), .BR_AW(12)) bus ();

  fsa_colscan #(
    .C_IMG_HW(12), .C_IMG_WW(12), .BR_NUM(4), .BR_AW(12), .C_RD_LAT(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sof       (sof),
    .rd_bmp    (rd_bmp),
    .width     (width),
    .win_left  (win_left),
    .win_width (win_width),
    .busy      (busy),
    .drop_cnt  (drop_cnt),
    .bus       (bus)
  );

  // Column record table.
  logic        vo [64];
  logic        vi [64];
  logic [11:0] to_ [64];
  logic [11:0] bo [64];
  logic [11:0] ti [64];
  logic [11:0] bi [64];

  // Memory model: data for a read appears C_RD_LAT=3 cycles after rd_en.
  logic        p_en [3];
  logic [11:0] p_addr [3];
  logic [5:0]  ridx;
  assign ridx = p_addr[2][5:0];
  assign bus.rd_val_outer = p_en[2] & vo[ridx];
  assign bus.rd_val_inner = p_en[2] & vi[ridx];
  assign bus.rd_top_outer = to_[ridx];
  assign bus.rd_bot_outer = bo[ridx];
  assign bus.rd_top_inner = ti[ridx];
  assign bus.rd_bot_inner = bi[ridx];

  logic [11:0] addr_q [$];
  int          sel_bad = 0;
  logic [3:0]  exp_sel = '0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        p_en[i]   <= 1'b0;
        p_addr[i] <= '0;
      end
    end else begin
      p_en[0]   <= bus.rd_en;
      p_addr[0] <= bus.rd_addr;
      for (int i = 1; i < 3; i++) begin
        p_en[i]   <= p_en[i-1];
        p_addr[i] <= p_addr[i-1];
      end
    end
    if (bus.rd_en === 1'b1) begin
      addr_q.push_back(bus.rd_addr);
      if (bus.rd_sel !== exp_sel) sel_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qfirst();
    return (addr_q.size() == 0) ? -1 : int'(addr_q[0]);
  endfunction

  function automatic int qlast();
    return (addr_q.size() == 0) ? -1 : int'(addr_q[addr_q.size()-1]);
  endfunction

  task automatic clear_tbl();
    for (int i = 0; i < 64; i++) begin
      vo[i] = 1'b0; vi[i] = 1'b0;
      to_[i] = '0; bo[i] = '0; ti[i] = '0; bi[i] = '0;
    end
  endtask

  // Pulse sof with the given window, then scramble the window inputs and
  // wait (bounded) for m_valid. lat counts cycles from the sof edge.
  task automatic run_scan(input logic [11:0] wl, input logic [11:0] ww,
                          input logic [11:0] wd, input logic [3:0] bmp,
                          output int lat);
    @(negedge clk);
    addr_q.delete();
    sel_bad   = 0;
    exp_sel   = bmp;
    win_left  = wl;
    win_width = ww;
    width     = wd;
    rd_bmp    = bmp;
    sof       = 1'b1;
    @(negedge clk);
    sof       = 1'b0;
    win_left  = 12'd40;
    win_width = 12'd1;
    width     = 12'd20;
    rd_bmp    = 4'b1000;
    lat = 1;
    while (bus.m_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic accept(input string tag);
    @(negedge clk);
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    check({tag, "_mvalid_drop"}, bus.m_valid, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int lat;
    int unstable;
    clear_tbl();
    bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_mvalid", bus.m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rden", bus.rd_en, 0);
    check("rst_sel", bus.rd_sel, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_found_o", bus.res_found_outer, 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic window 10..14 with two outer-valid columns.
    vo[11] = 1'b1; to_[11] = 12'd20; bo[11] = 12'd30;
    vo[13] = 1'b1; to_[13] = 12'd18; bo[13] = 12'd25;
    run_scan(12'd10, 12'd5, 12'd64, 4'b0001, lat);
    check("s1_lat", lat, 9);
    check("s1_found_o", bus.res_found_outer, 1);
    check("s1_found_i", bus.res_found_inner, 0);
    check("s1_left", bus.res_left, 11);
    check("s1_right", bus.res_right, 13);
    check("s1_top", bus.res_top_outer, 18);
    check("s1_bot", bus.res_bot_outer, 30);
    check("s1_naddr", addr_q.size(), 5);
    check("s1_afirst", qfirst(), 10);
    check("s1_alast", qlast(), 14);
    check("s1_sel", sel_bad, 0);
    check("s1_sel_done", bus.rd_sel, 0);
    accept("s1");

    // Window running past the image edge is clipped to 60..63.
    clear_tbl();
    vo[62] = 1'b1; to_[62] = 12'd5; bo[62] = 12'd7;
    vi[63] = 1'b1; ti[63] = 12'd1; bi[63] = 12'd2;
    run_scan(12'd60, 12'd10, 12'd64, 4'b0001, lat);
    check("clip_lat", lat, 8);
    check("clip_naddr", addr_q.size(), 4);
    check("clip_afirst", qfirst(), 60);
    check("clip_alast", qlast(), 63);
    check("clip_left", bus.res_left, 62);
    check("clip_right", bus.res_right, 62);
    check("clip_top_o", bus.res_top_outer, 5);
    check("clip_bot_o", bus.res_bot_outer, 7);
    check("clip_found_i", bus.res_found_inner, 1);
    check("clip_top_i", bus.res_top_inner, 1);
    check("clip_bot_i", bus.res_bot_inner, 2);
    accept("clip");

    // Hold DONE for 20 cycles with m_ready low, two dropped sof pulses.
    clear_tbl();
    vo[21] = 1'b1; to_[21] = 12'd3; bo[21] = 12'd9;
    vo[22] = 1'b1; to_[22] = 12'd5; bo[22] = 12'd4;
    run_scan(12'd20, 12'd3, 12'd64, 4'b0010, lat);
    check("hold_lat", lat, 7);
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sof = (i == 5 || i == 12);
      if (bus.m_valid !== 1'b1 || bus.res_left !== 12'd21 || bus.res_right !== 12'd22 ||
          bus.res_top_outer !== 12'd3 || bus.res_bot_outer !== 12'd9 ||
          bus.res_found_outer !== 1'b1)
        unstable++;
    end
    sof = 1'b0;
    check("hold_stable", unstable, 0);
    check("hold_drop", drop_cnt, 2);
    check("hold_sel", sel_bad, 0);
    // sof coinciding with the accepting handshake is also dropped.
    @(negedge clk);
    bus.m_ready = 1'b1;
    sof = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    sof = 1'b0;
    check("hs_drop", drop_cnt, 3);
    check("hs_busy", busy, 0);
    check("hs_mvalid", bus.m_valid, 0);

    // Empty window: straight to DONE with cleared results; drop saturation.
    run_scan(12'd5, 12'd0, 12'd64, 4'b0001, lat);
    check("empty_lat", lat, 1);
    check("empty_naddr", addr_q.size(), 0);
    check("empty_found_o", bus.res_found_outer, 0);
    check("empty_found_i", bus.res_found_inner, 0);
    check("empty_right", bus.res_right, 0);
    check("empty_top_o", bus.res_top_outer, 0);
    sof = 1'b1;
    repeat (260) @(negedge clk);
    sof = 1'b0;
    check("sat_drop", drop_cnt, 255);
    check("sat_mvalid", bus.m_valid, 1);
    accept("sat");

    // Reset asserted during the third SCAN cycle.
    @(negedge clk);
    win_left = 12'd0; win_width = 12'd10; width = 12'd64;
    rd_bmp = 4'b0001; exp_sel = 4'b0001;
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
    check("mid_rden", bus.rd_en, 1);
    @(negedge clk);
    @(negedge clk);
    check("mid_addr", bus.rd_addr, 2);
    reset = 1'b1;
    #1;
    check("mrst_rden", bus.rd_en, 0);
    check("mrst_addr", bus.rd_addr, 0);
    check("mrst_sel", bus.rd_sel, 0);
    check("mrst_busy", busy, 0);
    check("mrst_drop", drop_cnt, 0);
    check("mrst_mvalid", bus.m_valid, 0);
    @(negedge clk);
    reset = 1'b0;

    // Fresh scan after reset: bank 2, inner-only columns 3..5.
    clear_tbl();
    vi[3] = 1'b1; ti[3] = 12'd7; bi[3] = 12'd8;
    vi[4] = 1'b1; ti[4] = 12'd4; bi[4] = 12'd12;
    vi[5] = 1'b1; ti[5] = 12'd6; bi[5] = 12'd9;
    run_scan(12'd0, 12'd8, 12'd64, 4'b0100, lat);
    check("inr_lat", lat, 12);
    check("inr_naddr", addr_q.size(), 8);
    check("inr_sel", sel_bad, 0);
    check("inr_found_o", bus.res_found_outer, 0);
    check("inr_found_i", bus.res_found_inner, 1);
    check("inr_top_i", bus.res_top_inner, 4);
    check("inr_bot_i", bus.res_bot_inner, 12);
    check("inr_left", bus.res_left, 0);
    check("inr_drop", drop_cnt, 0);
    accept("inr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
